// File: rtl/fft_input_loader.sv
// Double-buffered FFT input loader: accepts a streaming sample per handshake,
// writes it to a two-bank sample RAM at the bit-reversed index, and hands
// complete frames to the FFT core in fill order.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   clr                   synchronous abort of the partial frame
//   s_valid/s_data/s_ready upstream sample handshake
//   mem_we/mem_addr/mem_wdata sample-RAM write port ({bank, bitrev(index)})
//   frame_valid/frame_bank frame presented to the FFT core
//   frame_ack             FFT core finished with frame_bank
//   fill_count            samples accepted into the current frame
module fft_input_loader #(
  parameter int unsigned BIT_WIDTH  = 10,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [BIT_WIDTH:0]    mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  frame_valid,
  output logic                  frame_bank,
  input  logic                  frame_ack,
  output logic [BIT_WIDTH-1:0]  fill_count
);

  typedef enum logic {FILL = 1'b0, STALL = 1'b1} state_t;

  state_t     state;
  logic       wr_bank;
  logic [1:0] full;          // bank holds a complete, unconsumed frame
  logic [1:0] rdy;           // bank's last RAM write has landed
  logic       done_d1;       // last sample of a frame was written last cycle
  logic       done_bank_d1;

  logic       hs;
  logic       last_hs;
  logic       ack;
  logic [1:0] full_next;
  logic [1:0] rdy_next;

  function automatic logic [BIT_WIDTH-1:0] bitrev(input logic [BIT_WIDTH-1:0] v);
    logic [BIT_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < int'(BIT_WIDTH); i++) r[i] = v[int'(BIT_WIDTH) - 1 - i];
    return r;
  endfunction

  // s_ready is a pure decode of the state register
  assign s_ready = (state == FILL);

  // Handshake/ack qualification and next bank occupancy
  always_comb begin
    hs        = s_valid && s_ready && !clr;
    last_hs   = hs && (fill_count == '1);
    ack       = frame_ack && frame_valid;
    full_next = full;
    rdy_next  = rdy;
    if (ack) begin
      full_next[frame_bank] = 1'b0;
      rdy_next[frame_bank]  = 1'b0;
    end
    if (last_hs) full_next[wr_bank] = 1'b1;
    if (done_d1) rdy_next[done_bank_d1] = 1'b1;
  end

  // Loader state, RAM write port and frame presentation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FILL;
      wr_bank      <= 1'b0;
      full         <= 2'b00;
      rdy          <= 2'b00;
      done_d1      <= 1'b0;
      done_bank_d1 <= 1'b0;
      fill_count   <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      frame_valid  <= 1'b0;
      frame_bank   <= 1'b0;
    end else begin
      mem_we <= hs;
      if (hs) begin
        mem_addr  <= {wr_bank, bitrev(fill_count)};
        mem_wdata <= s_data;
      end

      if (clr)     fill_count <= '0;
      else if (hs) fill_count <= fill_count + BIT_WIDTH'(1);

      full         <= full_next;
      rdy          <= rdy_next;
      done_d1      <= last_hs;
      done_bank_d1 <= wr_bank;
      if (last_hs) wr_bank <= ~wr_bank;

      // frame_bank walks the banks in fill order; it only moves on an ack
      if (ack) begin
        frame_valid <= 1'b0;
        frame_bank  <= ~frame_bank;
      end else if (!frame_valid && rdy[frame_bank]) begin
        frame_valid <= 1'b1;
      end

      case (state)
        FILL:    if (last_hs && full_next[~wr_bank]) state <= STALL;
        STALL:   if (!full[wr_bank]) state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_input_loader.sv
module tb_fft_input_loader;

  localparam int unsigned BW = 3;
  localparam int unsigned DW = 16;
  localparam int N = 1 << BW;

  logic          clk;
  logic          reset;
  logic          clr;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          mem_we;
  logic [BW:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          frame_valid;
  logic          frame_bank;
  logic          frame_ack;
  logic [BW-1:0] fill_count;

  fft_input_loader #(.BIT_WIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .frame_valid(frame_valid), .frame_bank(frame_bank),
    .frame_ack(frame_ack), .fill_count(fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of completed frames in fill order
  typedef struct {int bank; int ready_at;} frame_t;
  frame_t fq[$];
  int cyc, m_cnt, m_wbank, m_addr, m_data;
  bit m_stall, m_fv, m_fb, m_we;
  int wlog[$];

  function automatic int rev(input int k);
    int r = 0;
    for (int i = 0; i < int'(BW); i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  task automatic model_reset();
    fq.delete();
    m_cnt = 0; m_wbank = 0; m_stall = 0; m_fv = 0; m_fb = 0;
    m_we = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic model_edge();
    bit hs, ack, fv_pre, rel;
    frame_t f;
    cyc++;
    hs = s_valid && !m_stall && !clr;
    ack = frame_ack && m_fv;
    fv_pre = m_fv;
    rel = m_stall && (fq.size() < 2);
    m_we = hs;
    if (hs) begin
      m_addr = m_wbank * N + rev(m_cnt);
      m_data = int'(s_data);
    end
    if (ack) begin
      void'(fq.pop_front());
      m_fv = 0;
      m_fb = ~m_fb;
    end
    if (clr) m_cnt = 0;
    else if (hs) begin
      m_cnt++;
      if (m_cnt == N) begin
        m_cnt = 0;
        f.bank = m_wbank;
        f.ready_at = cyc + 2;
        fq.push_back(f);
        m_wbank ^= 1;
        if (fq.size() == 2) m_stall = 1;
      end
    end
    if (rel) m_stall = 0;
    if (!ack && !fv_pre && fq.size() > 0 && cyc >= fq[0].ready_at) begin
      m_fv = 1;
      m_fb = fq[0].bank[0];
    end
  endtask

  task automatic compare();
    check("s_ready", 32'(s_ready), 32'(!m_stall));
    check("mem_we", 32'(mem_we), 32'(m_we));
    if (m_we) begin
      check("mem_addr", 32'(mem_addr), 32'(m_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(m_data));
    end
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("frame_bank", 32'(frame_bank), 32'(m_fb));
    check("fill_count", 32'(fill_count), 32'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (mem_we) wlog.push_back(int'(mem_addr));
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_valid = 1'b0; clr = 1'b0; frame_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    compare();
  endtask

  task automatic send(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data = DW'(base + i);
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int exp_a[8];
    exp_a = '{0, 4, 2, 6, 1, 5, 3, 7};
    cyc = 0;
    reset = 1'b1; clr = 1'b0; s_valid = 1'b0; s_data = '0; frame_ack = 1'b0;
    model_reset();
    do_reset();

    // one frame, then the two-cycle presentation delay
    wlog.delete();
    send(8, 10);
    for (int i = 0; i < 8; i++)
      check("addr_order", (i < wlog.size()) ? 32'(wlog[i]) : 32'hffff_ffff, 32'(exp_a[i]));
    step();
    check("fv_1cyc", 32'(frame_valid), 32'd0);
    step();
    check("fv_2cyc", 32'(frame_valid), 32'd1);

    // second frame without ack -> stall
    send(8, 20);
    idle(2);
    check("stall_ready", 32'(s_ready), 32'd0);
    check("stall_bank", 32'(frame_bank), 32'd0);
    s_valid = 1'b1; s_data = 16'h55;
    step();
    s_valid = 1'b0;

    // ack releases bank 0; bank 1 presented next
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    step();
    check("ack_fb", 32'(frame_bank), 32'd1);
    check("ack_fv", 32'(frame_valid), 32'd1);
    check("ack_ready", 32'(s_ready), 32'd1);
    send(1, 40);
    check("after_ack_addr", 32'(mem_addr), 32'd0);

    // clr with a coincident valid sample
    do_reset();
    send(3, 50);
    s_valid = 1'b1; clr = 1'b1; s_data = 16'h99;
    step();
    clr = 1'b0; s_valid = 1'b0;
    check("clr_we", 32'(mem_we), 32'd0);
    check("clr_count", 32'(fill_count), 32'd0);
    send(1, 60);
    check("clr_next_addr", 32'(mem_addr), 32'd0);

    // last sample of bank 1 coincides with ack of bank 0
    do_reset();
    send(8, 100);
    idle(3);
    send(7, 200);
    s_valid = 1'b1; s_data = 16'd207; frame_ack = 1'b1;
    step();
    s_valid = 1'b0; frame_ack = 1'b0;
    check("coinc_ready", 32'(s_ready), 32'd1);
    idle(3);
    check("coinc_fb", 32'(frame_bank), 32'd1);

    // randomized traffic with spurious acks and occasional clr
    do_reset();
    for (int i = 0; i < 800; i++) begin
      s_valid = ($urandom % 4) != 0;
      s_data = DW'($urandom);
      frame_ack = ($urandom % 10) == 0;
      clr = ($urandom % 60) == 0;
      step();
    end
    s_valid = 1'b0; frame_ack = 1'b0; clr = 1'b0;

    // asynchronous reset mid-frame with a full frame pending
    do_reset();
    send(8, 300);
    idle(2);
    s_valid = 1'b1; s_data = 16'h77;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("arst_ready", 32'(s_ready), 32'd1);
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_wdata", 32'(mem_wdata), 32'd0);
    check("arst_fv", 32'(frame_valid), 32'd0);
    check("arst_fb", 32'(frame_bank), 32'd0);
    check("arst_count", 32'(fill_count), 32'd0);
    s_valid = 1'b0;
    do_reset();
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
